// File: rtl/load_v_stream.sv
// -----------------------------------------------------------------------------
// load_v_stream
//
// Strided vector loader. A command names the address of element 0, a length in
// elements and an address stride. The block reads one memory word per cycle
// and packs the elements into TILE_ELEMS-wide tiles. Tiles go out on a
// valid/ready stream. The final tile of a command is padded with zeros, and the
// padding slots issue no memory reads. No read is issued while a tile is
// waiting for capture or being presented, so there is no prefetch.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   cmd_valid    command request, accepted while cmd_ready is high
//   cmd_ready    high only while idle
//   cmd_addr     address of element 0
//   cmd_len      vector length in elements (0 completes with no reads or tiles)
//   cmd_stride   address increment between elements (wraps modulo 2^ADDR_WIDTH)
//   mem_re       memory read strobe, one word per cycle
//   mem_addr     read address, meaningful while mem_re is high
//   mem_rdata    read data, valid exactly MEM_LATENCY cycles after mem_re
//   tile_data    packed tile; element i sits at [i*DATA_WIDTH +: DATA_WIDTH]
//   tile_valid   tile available; data and tile_last are held until accepted
//   tile_ready   consumer accepts the tile (ignored unless a tile is presented)
//   tile_last    marks the final tile of the command
//   busy         high whenever not idle
//   done         one-cycle pulse on completion; cmd_ready is high in that cycle
// -----------------------------------------------------------------------------
module load_v_stream #(
  parameter int TILE_ELEMS  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 24,
  parameter int LEN_WIDTH   = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic [ADDR_WIDTH-1:0]            cmd_stride,
  output logic                             mem_re,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [TILE_ELEMS*DATA_WIDTH-1:0] tile_data,
  output logic                             tile_valid,
  input  logic                             tile_ready,
  output logic                             tile_last,
  output logic                             busy,
  output logic                             done
);

  localparam int SLOT_W = $clog2(TILE_ELEMS);
  // One extra bit so the slot index can reach len rounded up to a whole tile
  // without overflowing, even when len is close to 2^LEN_WIDTH.
  localparam int IDX_W  = LEN_WIDTH + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [IDX_W-1:0]      elem_idx;   // global slot index, counts zero-fill slots too
  logic                  tile_full;  // final slot of the current tile was captured

  logic [SLOT_W-1:0]     slot;
  logic                  slot_last;
  logic                  in_range;
  logic                  fetch_slot;
  logic                  issue_rd;

  // Read tags travel alongside the outstanding memory reads. A tag leaves the
  // pipe in the same cycle that its mem_rdata is valid.
  logic                  tag_vld_p  [MEM_LATENCY];
  logic                  tag_zero_p [MEM_LATENCY];
  logic                  tag_last_p [MEM_LATENCY];
  logic [SLOT_W-1:0]     tag_slot_p [MEM_LATENCY];

  logic                  cap_vld;
  logic                  cap_zero;
  logic                  cap_last;
  logic [SLOT_W-1:0]     cap_slot;
  logic [DATA_WIDTH-1:0] cap_data;

  // The low bits of the global index select the slot within the tile.
  // This works because TILE_ELEMS is a power of two.
  assign slot       = elem_idx[SLOT_W-1:0];
  assign slot_last  = (slot == SLOT_W'(TILE_ELEMS - 1));
  assign in_range   = (elem_idx < IDX_W'(len_q));
  assign fetch_slot = (state == S_FETCH);
  assign issue_rd   = fetch_slot && in_range;

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign mem_re     = issue_rd;
  assign mem_addr   = cur_addr;

  assign cap_vld    = tag_vld_p[MEM_LATENCY-1];
  assign cap_zero   = tag_zero_p[MEM_LATENCY-1];
  assign cap_last   = tag_last_p[MEM_LATENCY-1];
  assign cap_slot   = tag_slot_p[MEM_LATENCY-1];

  // Zero-fill slots take the same path through the tag pipe as real reads.
  // As a result, elements are always captured in issue order.
  function automatic logic [DATA_WIDTH-1:0] fill_elem(input logic zero,
                                                      input logic [DATA_WIDTH-1:0] rdata);
    return zero ? '0 : rdata;
  endfunction

  assign cap_data = fill_elem(cap_zero, mem_rdata);

  // ---- stage p0: tag entry at the issue slot, then fixed-latency shift ----
  // Clearing the valid bits on reset is what makes late mem_rdata from an
  // abandoned command harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_vld_p[i] <= 1'b0;
      end
    end else begin
      tag_vld_p[0] <= fetch_slot;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_zero_p[0] <= !in_range;
    tag_last_p[0] <= slot_last;
    tag_slot_p[0] <= slot;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_zero_p[i] <= tag_zero_p[i-1];
      tag_last_p[i] <= tag_last_p[i-1];
      tag_slot_p[i] <= tag_slot_p[i-1];
    end
  end

  // ---- stage p(MEM_LATENCY): capture into the tile register ----
  // Captures only happen while fetching or waiting. The tile is therefore
  // stable while it is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_data <= '0;
    end else if (cap_vld) begin
      for (int i = 0; i < TILE_ELEMS; i++) begin
        if (cap_slot == SLOT_W'(i)) begin
          tile_data[i*DATA_WIDTH +: DATA_WIDTH] <= cap_data;
        end
      end
    end
  end

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      elem_idx   <= '0;
      tile_full  <= 1'b0;
      tile_valid <= 1'b0;
      tile_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (cap_vld && cap_last) begin
        tile_full <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_addr <= cmd_addr;
            stride_q <= cmd_stride;
            len_q    <= cmd_len;
            elem_idx <= '0;
            state    <= (cmd_len == '0) ? S_DONE : S_FETCH;
          end
        end

        S_FETCH: begin
          elem_idx <= elem_idx + IDX_W'(1);
          if (issue_rd) begin
            cur_addr <= cur_addr + stride_q;
          end
          if (slot_last) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // At this point elem_idx has advanced past the whole tile, so it
          // equals (tile_idx+1)*TILE_ELEMS.
          if (tile_full) begin
            tile_full  <= 1'b0;
            tile_valid <= 1'b1;
            tile_last  <= !in_range;
            state      <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (tile_ready) begin
            tile_valid <= 1'b0;
            tile_last  <= 1'b0;
            state      <= tile_last ? S_DONE : S_FETCH;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_v_stream.sv
// -----------------------------------------------------------------------------
// tb_load_v_stream
//
// Two loaders run from the same command stream, one with read latency 1 and one
// with read latency 2. Each has its own memory model, in which memory content
// is a fixed function of the address. A negedge monitor logs every read
// address, every accepted tile and every done pulse. After each command, the
// logs are compared against an expected vector. That vector is computed
// directly from address + i*stride, the zero padding and the tile count.
// -----------------------------------------------------------------------------
module tb_load_v_stream;

  localparam int T = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [23:0]       cmd_addr = '0;
  logic [15:0]       cmd_len = '0;
  logic [23:0]       cmd_stride = '0;

  logic [1:0]        cmd_ready_w;
  logic [1:0]        mem_re_w;
  logic [1:0][23:0]  mem_addr_w;
  logic [1:0][7:0]   mem_rdata_w;
  logic [1:0][31:0]  tile_data_w;
  logic [1:0]        tile_valid_w;
  logic [1:0]        tile_ready_w;
  logic [1:0]        tile_last_w;
  logic [1:0]        busy_w;
  logic [1:0]        done_w;

  bit                ready_mode = 1'b0;  // 1: random tile_ready per cycle
  bit                ready_val  = 1'b1;
  logic [1:0]        rnd_rdy = '0;

  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_rdy <= 2'($urandom);
  assign tile_ready_w = ready_mode ? rnd_rdy : {2{ready_val}};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_v_stream #(
      .TILE_ELEMS (T),
      .DATA_WIDTH (8),
      .ADDR_WIDTH (24),
      .LEN_WIDTH  (16),
      .MEM_LATENCY(g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready_w[g]),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_stride(cmd_stride),
      .mem_re    (mem_re_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_rdata (mem_rdata_w[g]),
      .tile_data (tile_data_w[g]),
      .tile_valid(tile_valid_w[g]),
      .tile_ready(tile_ready_w[g]),
      .tile_last (tile_last_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );
  end

  // Memory content: four fixed words for the first directed case, hashed elsewhere.
  function automatic logic [7:0] memf(input logic [23:0] a);
    case (a)
      24'h000100: return 8'd11;
      24'h000101: return 8'd22;
      24'h000102: return 8'd33;
      24'h000103: return 8'd44;
      default:    return (a[7:0] * 8'd13) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  // Memory model: instance g answers a read g+1 cycles later.
  // Outside a valid read slot it drives random noise.
  logic [1:0][3:0] v_sh = '0;
  logic [23:0]     a_sh [2][4];
  logic [1:0][7:0] noise = '0;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      v_sh[g]     <= {v_sh[g][2:0], mem_re_w[g]};
      a_sh[g][0]  <= mem_addr_w[g];
      for (int k = 1; k < 4; k++) a_sh[g][k] <= a_sh[g][k-1];
      noise[g]    <= 8'($urandom);
    end
  end

  always_comb begin
    mem_rdata_w = '0;
    for (int g = 0; g < 2; g++) begin
      mem_rdata_w[g] = v_sh[g][g] ? memf(a_sh[g][g]) : noise[g];
    end
  end

  // Monitor logs
  logic [23:0] rd_log [2][1024];
  logic [31:0] tl_data [2][256];
  logic        tl_last [2][256];
  int          rd_n[2] = '{0, 0};
  int          tl_n[2] = '{0, 0};
  int          done_n[2] = '{0, 0};
  int          done_cyc[2] = '{0, 0};
  int          vld_n[2] = '{0, 0};
  int          unstable[2] = '{0, 0};
  int          pres_rd[2] = '{0, 0};
  logic        held[2] = '{1'b0, 1'b0};
  logic [32:0] held_v[2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        held[g] <= 1'b0;
      end else begin
        if (mem_re_w[g]) begin
          rd_log[g][rd_n[g] % 1024] <= mem_addr_w[g];
          rd_n[g] <= rd_n[g] + 1;
          if (tile_valid_w[g]) pres_rd[g] <= pres_rd[g] + 1;
        end
        if (tile_valid_w[g]) begin
          vld_n[g] <= vld_n[g] + 1;
          if (held[g] && ({tile_last_w[g], tile_data_w[g]} !== held_v[g]))
            unstable[g] <= unstable[g] + 1;
          if (tile_ready_w[g]) begin
            tl_data[g][tl_n[g] % 256] <= tile_data_w[g];
            tl_last[g][tl_n[g] % 256] <= tile_last_w[g];
            tl_n[g] <= tl_n[g] + 1;
            held[g] <= 1'b0;
          end else begin
            held[g]   <= 1'b1;
            held_v[g] <= {tile_last_w[g], tile_data_w[g]};
          end
        end else begin
          held[g] <= 1'b0;
        end
        if (done_w[g]) begin
          done_n[g]   <= done_n[g] + 1;
          done_cyc[g] <= cyc;
        end
      end
    end
  end

  int b_rd[2], b_tl[2], b_done[2], b_vld[2], b_unst[2], b_pres[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] l, input logic [23:0] s);
    chk("cmd_ready_before_issue", 64'(cmd_ready_w), 64'(2'b11));
    for (int g = 0; g < 2; g++) begin
      b_rd[g] = rd_n[g];     b_tl[g] = tl_n[g];    b_done[g] = done_n[g];
      b_vld[g] = vld_n[g];   b_unst[g] = unstable[g]; b_pres[g] = pres_rd[g];
    end
    cmd_addr = a; cmd_len = l; cmd_stride = s; cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid  = 1'b0;
    cmd_addr   = 24'($urandom);
    cmd_len    = 16'($urandom);
    cmd_stride = 24'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    int c = 0;
    while (!ok && c < 800) begin
      if (done_n[0] > b_done[0] && done_n[1] > b_done[1]) ok = 1'b1;
      else begin @(posedge clk); #1; c++; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_idle_ready"}, 64'(cmd_ready_w), 64'(2'b11));
    chk({tag, "_idle_busy"}, 64'(busy_w), 64'd0);
    chk({tag, "_done_low"}, 64'(done_w), 64'd0);
  endtask

  // Expected results computed from the command alone.
  task automatic check_cmd(input string tag, input logic [23:0] addr, input int len,
                           input logic [23:0] stride, input bit timing);
    int n;
    int idx;
    logic [23:0] ea;
    logic [31:0] et;
    n = (len + T - 1) / T;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_L%0d_rd_count", tag, g+1), 64'(rd_n[g] - b_rd[g]), 64'(len));
      for (int i = 0; i < len; i++) begin
        ea = 24'(longint'(addr) + longint'(i) * longint'(stride));
        chk($sformatf("%s_L%0d_addr%0d", tag, g+1, i),
            64'(rd_log[g][(b_rd[g] + i) % 1024]), 64'(ea));
      end
      chk($sformatf("%s_L%0d_tile_count", tag, g+1), 64'(tl_n[g] - b_tl[g]), 64'(n));
      for (int k = 0; k < n; k++) begin
        et = '0;
        for (int j = 0; j < T; j++) begin
          idx = k * T + j;
          if (idx < len) et[j*8 +: 8] = memf(24'(longint'(addr) + longint'(idx) * longint'(stride)));
        end
        chk($sformatf("%s_L%0d_tile%0d_data", tag, g+1, k),
            64'(tl_data[g][(b_tl[g] + k) % 256]), 64'(et));
        chk($sformatf("%s_L%0d_tile%0d_last", tag, g+1, k),
            64'(tl_last[g][(b_tl[g] + k) % 256]), 64'(k == n - 1));
      end
      chk($sformatf("%s_L%0d_done_pulses", tag, g+1), 64'(done_n[g] - b_done[g]), 64'd1);
      chk($sformatf("%s_L%0d_tile_stable", tag, g+1), 64'(unstable[g] - b_unst[g]), 64'd0);
      chk($sformatf("%s_L%0d_no_read_presenting", tag, g+1), 64'(pres_rd[g] - b_pres[g]), 64'd0);
      if (len == 0)
        chk($sformatf("%s_L%0d_no_tile_valid", tag, g+1), 64'(vld_n[g] - b_vld[g]), 64'd0);
      if (timing)
        chk($sformatf("%s_L%0d_done_cycle", tag, g+1), 64'(done_cyc[g] - acc),
            64'(n * (T + (g + 1) + 2) + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra, rs;
    logic [15:0] rl;
    int c;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_w), 64'(2'b11));
    chk("rst_busy", 64'(busy_w), 64'd0);
    chk("rst_mem_re", 64'(mem_re_w), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_w), 64'd0);
    chk("rst_tile_valid", 64'(tile_valid_w), 64'd0);
    chk("rst_tile_last", 64'(tile_last_w), 64'd0);
    chk("rst_tile_data", 64'(tile_data_w), 64'd0);
    chk("rst_done", 64'(done_w), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single full tile
    issue(24'h000100, 16'd4, 24'd1);
    wait_done("t1");
    check_cmd("t1", 24'h000100, 4, 24'd1, 1'b1);
    chk("t1_tile_const_L1", 64'(tl_data[0][b_tl[0] % 256]), 64'h2C21160B);
    chk("t1_tile_const_L2", 64'(tl_data[1][b_tl[1] % 256]), 64'h2C21160B);

    // 2: partial second tile, zero fill
    issue(24'h000200, 16'd6, 24'd1);
    wait_done("t2");
    check_cmd("t2", 24'h000200, 6, 24'd1, 1'b1);

    // 3: address wrap
    issue(24'hFFFFFE, 16'd4, 24'd2);
    wait_done("t3");
    check_cmd("t3", 24'hFFFFFE, 4, 24'd2, 1'b1);
    chk("t3_wrap_addr1", 64'(rd_log[1][(b_rd[1] + 1) % 1024]), 64'h000000);
    chk("t3_wrap_addr3", 64'(rd_log[1][(b_rd[1] + 3) % 1024]), 64'h000004);

    // 4: backpressure on the first tile
    ready_val = 1'b0;
    issue(24'h000340, 16'd8, 24'd3);
    c = 0;
    while (tile_valid_w != 2'b11 && c < 200) begin @(posedge clk); #1; c++; end
    chk("t4_tile0_valid", 64'(tile_valid_w), 64'(2'b11));
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held_valid", 64'(tile_valid_w), 64'(2'b11));
    chk("t4_held_no_read", 64'(mem_re_w), 64'd0);
    ready_val = 1'b1;
    wait_done("t4");
    check_cmd("t4", 24'h000340, 8, 24'd3, 1'b0);

    // 5: zero length
    issue(24'h000500, 16'd0, 24'd1);
    wait_done("t5");
    check_cmd("t5", 24'h000500, 0, 24'd1, 1'b1);

    // 6: reset in the middle of a fetch, then a clean command
    issue(24'h000600, 16'd8, 24'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(busy_w), 64'd0);
    chk("t6_rst_cmd_ready", 64'(cmd_ready_w), 64'(2'b11));
    chk("t6_rst_mem_re", 64'(mem_re_w), 64'd0);
    chk("t6_rst_mem_addr", 64'(mem_addr_w), 64'd0);
    chk("t6_rst_tile_valid", 64'(tile_valid_w), 64'd0);
    chk("t6_rst_tile_data", 64'(tile_data_w), 64'd0);
    chk("t6_rst_done", 64'(done_w), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(24'h000700, 16'd4, 24'd5);
    wait_done("t6");
    check_cmd("t6", 24'h000700, 4, 24'd5, 1'b1);

    // Randomized commands under random backpressure
    ready_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      ra = 24'($urandom);
      rl = 16'($urandom_range(1, 13));
      rs = (t % 3 == 2) ? 24'($urandom) : 24'($urandom_range(0, 4));
      issue(ra, rl, rs);
      wait_done($sformatf("r%0d", t));
      check_cmd($sformatf("r%0d", t), ra, int'(rl), rs, 1'b0);
    end
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    ra = 24'($urandom);
    rl = 16'($urandom_range(1, 13));
    rs = 24'($urandom);
    issue(ra, rl, rs);
    wait_done("rt");
    check_cmd("rt", ra, int'(rl), rs, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
